// File: rtl/seg_scan_decoder_pkg.sv
// ============================================================================
// seg_pkg : shared 7-segment pattern constants and codes (encoder/decoder)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  // Active-low patterns {a,b,c,d,e,f,g,dp}, dp off
  localparam logic [7:0] SEG_0   = 8'h03;
  localparam logic [7:0] SEG_1   = 8'h9F;
  localparam logic [7:0] SEG_2   = 8'h25;
  localparam logic [7:0] SEG_3   = 8'h0D;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h49;
  localparam logic [7:0] SEG_6   = 8'h41;
  localparam logic [7:0] SEG_7   = 8'h1F;
  localparam logic [7:0] SEG_8   = 8'h01;
  localparam logic [7:0] SEG_9   = 8'h09;
  localparam logic [7:0] SEG_DEF = 8'h91;

  localparam logic [3:0] DIG_DEF = 4'hF;
  localparam logic [3:0] DIG_BAD = 4'hE;

  typedef enum logic [1:0] {
    AN_BLANK   = 2'd0,
    AN_VALID   = 2'd1,
    AN_INVALID = 2'd2
  } an_class_e;

endpackage

`default_nettype wire

// File: rtl/seg_scan_decoder_if.sv
// ============================================================================
// seg_scan_decoder_if : scanned 7-segment bus in, decoded frame out
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface seg_scan_decoder_if #(
  parameter int NDIG = 4
);
  logic [7:0]        iSeg;
  logic [NDIG-1:0]   iAn;
  logic [4*NDIG-1:0] oDigits;
  logic [NDIG-1:0]   oDp;
  logic [NDIG-1:0]   oBad;
  logic              oFrameValid;
  logic              oAnErr;

  modport master (
    output iSeg, iAn,
    input  oDigits, oDp, oBad, oFrameValid, oAnErr
  );

  modport slave (
    input  iSeg, iAn,
    output oDigits, oDp, oBad, oFrameValid, oAnErr
  );
endinterface

`default_nettype wire

// File: rtl/seg_scan_decoder_decode.sv
// ============================================================================
// seg_pattern_decode : 7-bit active-low segment pattern -> {code, bad}
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] code_o,
  output logic       bad_o
);

  always_comb begin
    code_o = DIG_BAD;
    bad_o  = 1'b1;
    case (pat_i)
      SEG_0[7:1]:   begin code_o = 4'd0;    bad_o = 1'b0; end
      SEG_1[7:1]:   begin code_o = 4'd1;    bad_o = 1'b0; end
      SEG_2[7:1]:   begin code_o = 4'd2;    bad_o = 1'b0; end
      SEG_3[7:1]:   begin code_o = 4'd3;    bad_o = 1'b0; end
      SEG_4[7:1]:   begin code_o = 4'd4;    bad_o = 1'b0; end
      SEG_5[7:1]:   begin code_o = 4'd5;    bad_o = 1'b0; end
      SEG_6[7:1]:   begin code_o = 4'd6;    bad_o = 1'b0; end
      SEG_7[7:1]:   begin code_o = 4'd7;    bad_o = 1'b0; end
      SEG_8[7:1]:   begin code_o = 4'd8;    bad_o = 1'b0; end
      SEG_9[7:1]:   begin code_o = 4'd9;    bad_o = 1'b0; end
      SEG_DEF[7:1]: begin code_o = DIG_DEF; bad_o = 1'b0; end
      default:      begin code_o = DIG_BAD; bad_o = 1'b1; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
// ============================================================================
// seg_scan_decoder : recovers BCD digits/dp from a scanned 7-segment bus
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 3
) (
  input  logic                iClk,
  input  logic                iRst,
  seg_scan_decoder_if.slave   bus
);

  localparam int              SW    = 8 + NDIG;
  localparam logic [CNT_W-1:0] c_SAT = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] c_PRE = CNT_W'(STABLE_CYC - 2);

  logic [SW-1:0]     sample_q, prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic [4*NDIG-1:0] shd_dig_q, shd_dig_d;
  logic [NDIG-1:0]   shd_dp_q, shd_dp_d, shd_bad_q, shd_bad_d;
  logic [4*NDIG-1:0] digits_q;
  logic [NDIG-1:0]   dp_q, bad_q;
  logic              fv_q, anerr_q;

  logic [NDIG-1:0]   an_w, sel_w, seen_set_w;
  logic [7:0]        seg_w;
  logic [3:0]        code_w;
  logic              bad_w, run_ok_w, cap_w, frame_w;
  an_class_e         cls_w;

  assign an_w  = sample_q[NDIG-1:0];
  assign seg_w = sample_q[SW-1:NDIG];
  assign sel_w = ~an_w;

  always_comb begin
    if (&an_w)
      cls_w = AN_BLANK;
    else if ((sel_w & (sel_w - NDIG'(1))) == '0)
      cls_w = AN_VALID;
    else
      cls_w = AN_INVALID;
  end

  seg_pattern_decode u_decode (
    .pat_i  (seg_w[7:1]),
    .code_o (code_w),
    .bad_o  (bad_w)
  );

  // The capture fires on the single cycle the run counter steps into STABLE_CYC-1
  assign run_ok_w = (sample_q == prev_q) && (cls_w == AN_VALID);
  assign cap_w    = run_ok_w && (cnt_q == c_PRE);

  always_comb begin
    cnt_d = '0;
    if (run_ok_w)
      cnt_d = (cnt_q == c_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    shd_dig_d  = shd_dig_q;
    shd_dp_d   = shd_dp_q;
    shd_bad_d  = shd_bad_q;
    for (int k = 0; k < NDIG; k++) begin
      if (cap_w && sel_w[k]) begin
        shd_dig_d[4*k +: 4] = code_w;
        shd_dp_d[k]         = ~seg_w[0];
        shd_bad_d[k]        = bad_w;
      end
    end
    seen_set_w = seen_q | (cap_w ? sel_w : '0);
    frame_w    = cap_w && (&seen_set_w);
    seen_d     = frame_w ? '0 : seen_set_w;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sample_q  <= '1;
      prev_q    <= '1;
      cnt_q     <= '0;
      seen_q    <= '0;
      shd_dig_q <= '0;
      shd_dp_q  <= '0;
      shd_bad_q <= '0;
      digits_q  <= '0;
      dp_q      <= '0;
      bad_q     <= '0;
      fv_q      <= 1'b0;
      anerr_q   <= 1'b0;
    end else begin
      sample_q  <= {bus.iSeg, bus.iAn};
      prev_q    <= sample_q;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      shd_dig_q <= shd_dig_d;
      shd_dp_q  <= shd_dp_d;
      shd_bad_q <= shd_bad_d;
      fv_q      <= frame_w;
      anerr_q   <= (cls_w == AN_INVALID);
      if (frame_w) begin
        digits_q <= shd_dig_d;
        dp_q     <= shd_dp_d;
        bad_q    <= shd_bad_d;
      end
    end
  end

  assign bus.oDigits     = digits_q;
  assign bus.oDp         = dp_q;
  assign bus.oBad        = bad_q;
  assign bus.oFrameValid = fv_q;
  assign bus.oAnErr      = anerr_q;

endmodule

`default_nettype wire

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Monitors a multiplexed, active-low 8-bit 7-segment bus (segment pattern plus digit anodes) and recovers the displayed BCD digits and decimal points.
- Inverse of the team's decimal-to-7-segment encoder. Used as a loop-back checker on display outputs and as a front end for reading an external scanned display into the UART path.
- Requires each digit's pattern to be stable for a programmable number of cycles before capturing it. Publishes one complete frame once every digit slot has been captured.

Parameters:
- NDIG, 4, number of multiplexed digits (anode width).
- STABLE_CYC, 4, consecutive identical samples required before capture (≥2).
- CNT_W, 3, stability counter width; must hold STABLE_CYC.

Ports:
- iClk  in  1  system clock; all logic on the rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iSeg  in  8  active-low pattern: bit7..bit1 = a..g, bit0 = dp.
- iAn  in  NDIG  active-low anode select; iAn[k]=0 selects digit k.
- oDigits  out  4*NDIG  decoded codes; slot k at [4k+3:4k].
- oDp  out  NDIG  decimal point per slot, 1 = lit.
- oBad  out  NDIG  1 = slot pattern not in the decode table.
- oFrameValid  out  1  one-cycle pulse when oDigits/oDp/oBad update.
- oAnErr  out  1  high while the sampled anode is multi-hot.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - Seen mask 0, slot shadows 0, stability counter 0.
  - Sample register = all ones (blank, all anodes off).
- Stage 1: the sample register captures {iSeg,iAn} every cycle.
- Anode classification of the sample:
  - one-hot low → valid;
  - all ones → blanking;
  - any other → invalid.
- Stability counter:
  - Cleared when the sample differs from the previous sample, or the anode is not valid.
  - Otherwise increments, saturating at STABLE_CYC.
- Capture:
  - Occurs once per stable run, in the cycle the counter reaches STABLE_CYC-1 (i.e. STABLE_CYC identical valid samples).
  - Writes code/dp/bad into shadow slot k and sets seen[k].
  - If iSeg/iAn change at edge E and then stay constant, the capture register updates at edge E+STABLE_CYC.
- Decode, on iSeg[7:1]:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1001000 (default glyph) → 4'hF, bad=0.
  - Anything else → 4'hE, bad=1.
  - dp = ~iSeg[0].
- Repeated capture of a slot already seen overwrites its shadow; seen stays set.
- Frame completion:
  - Occurs on the edge where a capture makes seen all ones.
  - On that same edge: oDigits/oDp/oBad load the shadows including the new capture, oFrameValid=1 for one cycle, seen clears.
  - Outputs hold between frames.
- Blanking samples: not an error, reset the counter, no capture.
- Invalid anodes: oAnErr=1 (registered, one cycle after the sample stage) for each such sample; counter cleared; no capture.
- Reset mid-frame discards the partial frame and the previous outputs.
- No back-pressure. Frames are produced at the scan rate.

Decomposition:
- Package seg_pkg holds:
  - pattern constants SEG_0..SEG_9 and SEG_DEF = 8'h91 (full 8-bit, dp off);
  - codes DIG_DEF = 4'hF and DIG_BAD = 4'hE;
  - shared with the encoder.
- One combinational sub-module, seg_pattern_decode: 7-bit pattern → {code[3:0], bad}.
- Top holds the sample register, stability counter, seen mask, shadows and output registers.

Test Plan:
- Reset: assert iRst mid-activity → all outputs 0 immediately. After release, no oFrameValid until four fresh captures.
- Normal frame: drive (iAn=1110, iSeg=9F), (1101, 25), (1011, 0D), (0111, 99), each held 6 cycles → single oFrameValid pulse; oDigits=16'h4321, oDp=0, oBad=0.
- Glitch rejection: hold a pattern only STABLE_CYC-1 cycles between stable digits → no capture, slot unchanged; full frame still completes with the correct values.
- Bad/default/dp: slot 0 = 8'hFF, slot 1 = 8'h91, slot 2 = 8'h02 (digit 0 with dp) → slot0=E/bad=1, slot1=F/bad=0, slot2=0/dp=1.
- Anode error: iAn=1100 held 8 cycles → oAnErr high those cycles (delayed one cycle after the sample stage), no capture, seen unchanged. iAn=1111 → no oAnErr.
- Round-trip: encoder drives the bus for every input 0..15 → decoded 0..9 match; inputs 10..15 → 4'hF.
